// File: rtl/frame_pkg.sv
// Shared types and constants for the frame RAM writer and bitmap lookup.
//   FRAME_W/FRAME_H : frame geometry (powers of two)
//   PIX_W           : palette index width
//   RUN_W           : run-length field width; a token encodes run+1 pixels
package frame_pkg;
    localparam int FRAME_W = 32;
    localparam int FRAME_H = 32;
    localparam int PIX_W   = 3;
    localparam int RUN_W   = 5;
    localparam int X_W     = $clog2(FRAME_W);
    localparam int Y_W     = $clog2(FRAME_H);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic [RUN_W-1:0] run;
        pixel_t           colour;
    } rle_token_t;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} wr_state_t;
endpackage

// File: rtl/frame_rle_writer_if.sv
// Token stream plus frame RAM write port.
//   s_valid/s_ready/s_data/s_sof : run-length token stream (source -> writer)
//   wr_en/wr_x/wr_y/wr_pixel     : frame RAM write port (writer -> RAM)
// slave  : the writer side; master : the token source / RAM model side.
interface frame_rle_writer_if;
    import frame_pkg::*;

    logic           s_valid;
    logic           s_ready;
    rle_token_t     s_data;
    logic           s_sof;
    logic           wr_en;
    logic [X_W-1:0] wr_x;
    logic [Y_W-1:0] wr_y;
    pixel_t         wr_pixel;

    modport slave  (input  s_valid, s_data, s_sof,
                    output s_ready, wr_en, wr_x, wr_y, wr_pixel);
    modport master (output s_valid, s_data, s_sof,
                    input  s_ready, wr_en, wr_x, wr_y, wr_pixel);
endinterface

// File: rtl/raster_addr_ctr.sv
// Raster-order x/y address counter.
//   clear   : return to (0,0); wins over advance
//   advance : step one pixel, wrapping x at end of row and bumping y
//   x, y    : current address
//   last    : current address is the final pixel of the frame
module raster_addr_ctr
    import frame_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (advance) begin
            r_x <= r_x + 1'b1;
            if (r_x == X_W'(FRAME_W - 1))
                r_y <= r_y + 1'b1;
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = (r_x == X_W'(FRAME_W - 1)) && (r_y == Y_W'(FRAME_H - 1));
endmodule

// File: rtl/frame_rle_writer.sv
// Expands run-length tokens into raster-ordered frame RAM writes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : token stream in, frame RAM write port out
//   frame_done  : one-cycle pulse after the last pixel of a complete frame
//   frame_err   : sticky; set on overrun or mid-frame restart, cleared by s_sof from IDLE
//   busy        : high outside IDLE
module frame_rle_writer
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    frame_rle_writer_if.slave bus,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    wr_state_t        r_state, w_next;
    pixel_t           r_colour;
    logic [RUN_W-1:0] r_run;
    logic             r_err;

    logic             w_clear, w_adv, w_load, w_err_set, w_err_clr, w_last;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    rle_token_t       w_tok;

    assign w_tok = bus.s_data;

    raster_addr_ctr u_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .advance (w_adv),
        .x       (w_x),
        .y       (w_y),
        .last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        bus.s_ready = 1'b0;
        bus.wr_en   = 1'b0;
        frame_done  = 1'b0;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                bus.s_ready = 1'b1;
                // tokens without s_sof are swallowed here
                if (bus.s_valid && bus.s_sof) begin
                    w_load    = 1'b1;
                    w_clear   = 1'b1;
                    w_err_clr = 1'b1;
                    w_next    = RUN;
                end
            end
            RUN: begin
                bus.wr_en = 1'b1;
                w_adv     = 1'b1;
                if (w_last) begin
                    // frame complete; leftover run pixels are dropped
                    w_next = DONE;
                    if (r_run != '0) w_err_set = 1'b1;
                end else if (r_run == '0) begin
                    // last pixel of this run: take the next token without a bubble
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        w_load = 1'b1;
                        if (bus.s_sof) begin
                            w_clear   = 1'b1;
                            w_err_set = 1'b1;
                        end
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_load = 1'b1;
                    w_next = RUN;
                    if (bus.s_sof) begin
                        w_clear   = 1'b1;
                        w_err_set = 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_colour <= '0;
            r_run    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_load) begin
                r_colour <= w_tok.colour;
                r_run    <= w_tok.run;
            end else if (r_state == RUN) begin
                r_run <= r_run - 1'b1;
            end
            if (w_err_clr)      r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end

    assign bus.wr_x     = w_x;
    assign bus.wr_y     = w_y;
    assign bus.wr_pixel = r_colour;
    assign frame_err    = r_err;
    assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_frame_rle_writer.sv
// Self-checking bench for frame_rle_writer: single-token table, directed
// multi-cycle sequences, and a randomized token stream against a
// pixel-index model of the frame.
module tb_frame_rle_writer;
    import frame_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_done, frame_err, busy;

    frame_rle_writer_if tb_if();

    frame_rle_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (tb_if),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int x; int y; int pix; int cyc; } wr_t;
    typedef struct { bit sof; int run; int col; int gap; } tok_t;
    typedef struct { bit sof; int run; int col; int exp_n; int exp_x; int exp_y; bit exp_busy; } vec_t;

    wr_t  act_q[$];
    wr_t  exp_q[$];
    int   done_q[$];
    tok_t seq[$];
    int   exp_done;
    bit   exp_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    // observed writes and done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (tb_if.wr_en)
                act_q.push_back('{x: int'(tb_if.wr_x), y: int'(tb_if.wr_y),
                                  pix: int'(tb_if.wr_pixel), cyc: cyc});
            if (frame_done) done_q.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one token starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input tok_t t);
        int g = 0;
        bit acc;
        tb_if.s_valid = 1'b1;
        tb_if.s_data  = {5'(t.run), 3'(t.col)};
        tb_if.s_sof   = t.sof;
        forever begin
            #1 acc = tb_if.s_ready;
            @(negedge clk);
            if (acc) break;
            g++;
            if (g > 3000) begin
                chk("accept_timeout", g, 0);
                break;
            end
        end
        tb_if.s_valid = 1'b0;
        tb_if.s_sof   = 1'b0;
    endtask

    // Reference: walk the frame as a linear pixel index 0..1023.
    task automatic model();
        bit in_f = 1'b0;
        int p = 0;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 1'b0;
        foreach (seq[i]) begin
            if (seq[i].sof) begin
                exp_err = in_f;
                in_f    = 1'b1;
                p       = 0;
            end
            if (!in_f) continue;
            for (int k = 0; k <= seq[i].run; k++) begin
                if (p == FRAME_W * FRAME_H) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_q.push_back('{x: p % FRAME_W, y: p / FRAME_W, pix: seq[i].col, cyc: 0});
                p++;
            end
            if (p == FRAME_W * FRAME_H) begin
                in_f = 1'b0;
                exp_done++;
            end
        end
    endtask

    task automatic run_seq(input string nm);
        int shown = 0;
        model();
        act_q.delete();
        done_q.delete();
        foreach (seq[i]) begin
            send(seq[i]);
            repeat (seq[i].gap) @(negedge clk);
        end
        repeat (45) @(negedge clk);
        chk({nm, "_wr_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_cmp++;
            if (act_q[i].x != exp_q[i].x || act_q[i].y != exp_q[i].y || act_q[i].pix != exp_q[i].pix) begin
                n_bad++;
                if (shown < 8)
                    $display("FAIL %s_wr[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", nm, i,
                             act_q[i].x, act_q[i].y, act_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].pix);
                shown++;
            end
        end
        chk({nm, "_done_count"}, done_q.size(), exp_done);
        chk({nm, "_frame_err"}, int'(frame_err), int'(exp_err));
    endtask

    initial begin
        vec_t vt[5];
        tok_t t;
        int   bad_pix;

        vt[0] = '{sof: 1, run: 0,  col: 1, exp_n: 1,  exp_x: 1,  exp_y: 0, exp_busy: 1};
        vt[1] = '{sof: 1, run: 31, col: 6, exp_n: 32, exp_x: 0,  exp_y: 1, exp_busy: 1};
        vt[2] = '{sof: 0, run: 5,  col: 2, exp_n: 0,  exp_x: 0,  exp_y: 0, exp_busy: 0};
        vt[3] = '{sof: 1, run: 3,  col: 4, exp_n: 4,  exp_x: 4,  exp_y: 0, exp_busy: 1};
        vt[4] = '{sof: 1, run: 16, col: 3, exp_n: 17, exp_x: 17, exp_y: 0, exp_busy: 1};

        tb_if.s_valid = 1'b0;
        tb_if.s_data  = '0;
        tb_if.s_sof   = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        // reset state
        chk("rst_s_ready", int'(tb_if.s_ready), 1);
        chk("rst_wr_en", int'(tb_if.wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_addr", int'({tb_if.wr_x, tb_if.wr_y}), 0);

        // single-token table
        for (int i = 0; i < 5; i++) begin
            do_reset();
            act_q.delete();
            t = '{sof: vt[i].sof, run: vt[i].run, col: vt[i].col, gap: 0};
            send(t);
            repeat (40) @(negedge clk);
            chk($sformatf("vec%0d_nwr", i), act_q.size(), vt[i].exp_n);
            chk($sformatf("vec%0d_x", i), int'(tb_if.wr_x), vt[i].exp_x);
            chk($sformatf("vec%0d_y", i), int'(tb_if.wr_y), vt[i].exp_y);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
            chk($sformatf("vec%0d_wr_en", i), int'(tb_if.wr_en), 0);
            bad_pix = 0;
            foreach (act_q[j]) if (act_q[j].pix != vt[i].col) bad_pix++;
            chk($sformatf("vec%0d_pix", i), bad_pix, 0);
        end

        // full single-colour frame, no gaps
        do_reset();
        seq.delete();
        for (int i = 0; i < 32; i++) seq.push_back('{sof: (i == 0), run: 31, col: 5, gap: 0});
        run_seq("full");
        if (act_q.size() == 1024 && done_q.size() == 1) begin
            chk("full_contig", act_q[1023].cyc - act_q[0].cyc, 1023);
            chk("full_done_cyc", done_q[0] - act_q[1023].cyc, 1);
        end

        // alternating run=0 tokens
        do_reset();
        seq.delete();
        for (int i = 0; i < 16; i++) seq.push_back('{sof: (i == 0), run: 0, col: 1 + (i % 2), gap: 0});
        run_seq("alt");
        if (act_q.size() == 16) chk("alt_contig", act_q[15].cyc - act_q[0].cyc, 15);

        // source stall after a run of 4
        do_reset();
        act_q.delete();
        send('{sof: 1, run: 3, col: 4, gap: 0});
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("stall_wr_en", int'(tb_if.wr_en), 0);
            chk("stall_addr", int'(tb_if.wr_x) + 32 * int'(tb_if.wr_y), 4);
            @(negedge clk);
        end
        send('{sof: 0, run: 0, col: 6, gap: 0});
        repeat (5) @(negedge clk);
        chk("stall_nwr", act_q.size(), 5);
        if (act_q.size() == 5) begin
            chk("stall_resume_x", act_q[4].x, 4);
            chk("stall_resume_pix", act_q[4].pix, 6);
        end

        // overrun: last token starts at pixel 1016
        do_reset();
        seq.delete();
        for (int i = 0; i < 31; i++) seq.push_back('{sof: (i == 0), run: 31, col: 2, gap: 0});
        seq.push_back('{sof: 0, run: 23, col: 3, gap: 0});
        seq.push_back('{sof: 0, run: 31, col: 6, gap: 0});
        run_seq("ovr");
        if (act_q.size() > 0) chk("ovr_last_addr", act_q[$].x + 32 * act_q[$].y, 1023);
        chk("ovr_err_set", int'(frame_err), 1);
        seq.delete();
        seq.push_back('{sof: 1, run: 0, col: 3, gap: 0});
        run_seq("ovr_clr");

        // mid-frame restart after 40 pixels
        do_reset();
        seq.delete();
        seq.push_back('{sof: 1, run: 31, col: 1, gap: 0});
        seq.push_back('{sof: 0, run: 7,  col: 1, gap: 0});
        seq.push_back('{sof: 1, run: 2,  col: 7, gap: 0});
        run_seq("restart");

        // reset mid-run at (10,3), then IDLE filtering
        do_reset();
        act_q.delete();
        send('{sof: 1, run: 31, col: 5, gap: 0});
        for (int i = 0; i < 3; i++) send('{sof: 0, run: 31, col: 5, gap: 0});
        repeat (10) @(negedge clk);
        chk("mid_addr", int'(tb_if.wr_x) + 32 * int'(tb_if.wr_y), 10 + 32 * 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", int'(tb_if.wr_en), 0);
        chk("mid_rst_s_ready", int'(tb_if.s_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        act_q.delete();
        send('{sof: 0, run: 4, col: 3, gap: 0});
        repeat (10) @(negedge clk);
        chk("idle_filter_nwr", act_q.size(), 0);
        chk("idle_filter_busy", int'(busy), 0);

        // randomized stream with gaps and stray restarts
        do_reset();
        seq.delete();
        for (int i = 0; i < 200; i++) begin
            t.sof = (i == 0) || ($urandom_range(0, 29) == 0);
            t.run = int'($urandom_range(0, 31));
            t.col = int'($urandom_range(0, 7));
            t.gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            seq.push_back(t);
        end
        run_seq("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
